// File: rtl/sharpen_window_former_if.sv
// Line-buffer tap bundle in, 3x3 window bundle out.
// slave = window former side, master = producer/consumer side.
interface sharpen_window_former_if #(
  parameter int WIDTH     = 8,
  parameter int LINE_BITS = 10,
  parameter int ROW_BITS  = 10
);
  logic [WIDTH-1:0]     data_in_0;
  logic [WIDTH-1:0]     data_in_1;
  logic [WIDTH-1:0]     data_in_2;
  logic                 data_in_valid;
  logic [9*WIDTH-1:0]   window_out;
  logic                 window_valid;
  logic [LINE_BITS-1:0] center_col;
  logic [ROW_BITS-1:0]  center_row;
  logic                 line_done;
  logic                 frame_done;

  modport master (
    output data_in_0, data_in_1, data_in_2, data_in_valid,
    input  window_out, window_valid, center_col, center_row,
    input  line_done, frame_done
  );

  modport slave (
    input  data_in_0, data_in_1, data_in_2, data_in_valid,
    output window_out, window_valid, center_col, center_row,
    output line_done, frame_done
  );
endinterface

// File: rtl/sharpen_window_former.sv
// 3x3 window former for the sharpening kernel.
// Define BORDER_REPLICATE_EN to emit edge-column windows.
module sharpen_window_former #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 512,
  parameter int LINE_BITS = 10,
  parameter int HEIGHT    = 512,
  parameter int ROW_BITS  = 10
) (
  input logic clk,
  input logic reset,
  sharpen_window_former_if.slave bus
);

  localparam logic [LINE_BITS-1:0] LAST_COL = LINE_BITS'(DEPTH - 1);
  localparam logic [LINE_BITS-1:0] ONE_COL  = LINE_BITS'(1);
  localparam logic [ROW_BITS-1:0]  LAST_ROW = ROW_BITS'(HEIGHT - 3);
  localparam logic [ROW_BITS-1:0]  ONE_ROW  = ROW_BITS'(1);

`ifdef BORDER_REPLICATE_EN
  typedef enum logic [1:0] {FILL, ACTIVE, FLUSH} state_t;
`else
  typedef enum logic [0:0] {FILL, ACTIVE} state_t;
`endif

  state_t state, state_n;

  logic [LINE_BITS-1:0] col_cnt, col_cnt_n, ctr_col;
  logic [ROW_BITS-1:0]  row_cnt, row_cnt_n;
  logic [WIDTH-1:0]     pix [3];
  logic [WIDTH-1:0]     col0 [3];
  logic [WIDTH-1:0]     col1 [3];
  logic [WIDTH-1:0]     lft [3];
  logic [WIDTH-1:0]     mid [3];
  logic [WIDTH-1:0]     rgt [3];
  logic [9*WIDTH-1:0]   win_n;
  logic                 emit, last, frame;

  logic [9*WIDTH-1:0]   win_q;
  logic                 valid_q, line_q, frame_q;
  logic [LINE_BITS-1:0] ccol_q;
  logic [ROW_BITS-1:0]  crow_q;

  // Row 0 of the window is the oldest line.
  always_comb begin
    pix[0] = bus.data_in_2;
    pix[1] = bus.data_in_1;
    pix[2] = bus.data_in_0;
  end

  always_comb begin
    state_n   = state;
    col_cnt_n = col_cnt;
    row_cnt_n = row_cnt;
    emit      = 1'b0;
    last      = 1'b0;
    frame     = 1'b0;
    ctr_col   = col_cnt - ONE_COL;
    lft       = col1;
    mid       = col0;
    rgt       = pix;
    win_n     = '0;
    unique case (state)
      FILL: begin
        if (bus.data_in_valid) begin
          col_cnt_n = col_cnt + ONE_COL;
          if (col_cnt == ONE_COL) begin
            state_n = ACTIVE;
`ifdef BORDER_REPLICATE_EN
            emit = 1'b1;
            lft  = col0;
`endif
          end
        end
      end
      ACTIVE: begin
        if (bus.data_in_valid) begin
          emit = 1'b1;
          if (col_cnt == LAST_COL) begin
            col_cnt_n = '0;
`ifdef BORDER_REPLICATE_EN
            state_n = FLUSH;
`else
            state_n = FILL;
            last    = 1'b1;
`endif
          end else begin
            col_cnt_n = col_cnt + ONE_COL;
          end
        end
      end
`ifdef BORDER_REPLICATE_EN
      // A beat here is already column 0 of the next line.
      FLUSH: begin
        emit    = 1'b1;
        last    = 1'b1;
        state_n = FILL;
        ctr_col = LAST_COL;
        lft     = col1;
        mid     = col0;
        rgt     = col0;
        if (bus.data_in_valid)
          col_cnt_n = col_cnt + ONE_COL;
      end
`endif
      default: state_n = FILL;
    endcase
    if (last) begin
      frame     = (row_cnt == LAST_ROW);
      row_cnt_n = frame ? '0 : row_cnt + ONE_ROW;
    end
    for (int r = 0; r < 3; r++) begin
      win_n[WIDTH*(3*r)   +: WIDTH] = lft[r];
      win_n[WIDTH*(3*r+1) +: WIDTH] = mid[r];
      win_n[WIDTH*(3*r+2) +: WIDTH] = rgt[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= FILL;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
      for (int r = 0; r < 3; r++) begin
        col0[r] <= '0;
        col1[r] <= '0;
      end
      win_q   <= '0;
      valid_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      ccol_q  <= '0;
      crow_q  <= '0;
    end else begin
      col_cnt <= col_cnt_n;
      row_cnt <= row_cnt_n;
      if (bus.data_in_valid) begin
        for (int r = 0; r < 3; r++) begin
          col1[r] <= col0[r];
          col0[r] <= pix[r];
        end
      end
      valid_q <= emit;
      line_q  <= last;
      frame_q <= frame;
      if (emit) begin
        win_q  <= win_n;
        ccol_q <= ctr_col;
        crow_q <= row_cnt;
      end
    end
  end

  assign bus.window_out   = win_q;
  assign bus.window_valid = valid_q;
  assign bus.center_col   = ccol_q;
  assign bus.center_row   = crow_q;
  assign bus.line_done    = line_q;
  assign bus.frame_done   = frame_q;

endmodule

// File: tb/tb_sharpen_window_former.sv
// Scoreboard bench for sharpen_window_former, DEPTH=5 HEIGHT=4.
// Builds with or without BORDER_REPLICATE_EN.
module tb_sharpen_window_former;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 5;
  localparam int HEIGHT = 4;
  localparam int LB     = 10;
  localparam int RB     = 10;
`ifdef BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sharpen_window_former_if #(
    .WIDTH(WIDTH), .LINE_BITS(LB), .ROW_BITS(RB)
  ) bus ();

  sharpen_window_former #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LINE_BITS(LB),
    .HEIGHT(HEIGHT), .ROW_BITS(RB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [9*WIDTH-1:0] win;
    int                 col;
    int                 row;
    bit                 line;
    bit                 frame;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  int got_frames = 0;
  int mcol = 0;
  int mline = 0;
  int lsq = 0;
  logic [WIDTH-1:0] mem [3][DEPTH];

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(int c0, int c1, int c2, int ctr, bit lst);
    exp_t e;
    e.win = '0;
    for (int w = 0; w < 3; w++) begin
      e.win[WIDTH*(3*w)   +: WIDTH] = mem[w][c0];
      e.win[WIDTH*(3*w+1) +: WIDTH] = mem[w][c1];
      e.win[WIDTH*(3*w+2) +: WIDTH] = mem[w][c2];
    end
    e.col   = ctr;
    e.row   = mline;
    e.line  = lst;
    e.frame = lst && (mline == HEIGHT - 3);
    if (e.frame) exp_frames++;
    q.push_back(e);
  endtask

  // data_in_k = k*16 + col, shifted per line so lines differ.
  task automatic beat();
    logic [WIDTH-1:0] v [3];
    for (int k = 0; k < 3; k++) begin
      v[k] = WIDTH'(k * 16 + mcol + 3 * lsq);
      mem[2-k][mcol] = v[k];
    end
    bus.data_in_0     = v[0];
    bus.data_in_1     = v[1];
    bus.data_in_2     = v[2];
    bus.data_in_valid = 1'b1;
    if (BORDER && mcol == 1)
      push(0, 0, 1, 0, 1'b0);
    if (mcol >= 2)
      push(mcol - 2, mcol - 1, mcol, mcol - 1,
           !BORDER && mcol == DEPTH - 1);
    if (BORDER && mcol == DEPTH - 1)
      push(DEPTH - 2, DEPTH - 1, DEPTH - 1, DEPTH - 1, 1'b1);
    if (mcol == DEPTH - 1) begin
      mcol  = 0;
      mline = (mline == HEIGHT - 3) ? 0 : mline + 1;
      lsq++;
    end else begin
      mcol++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit quiet);
    bus.data_in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (quiet) check("gap_no_window", bus.window_valid, 1'b0);
    end
  endtask

  task automatic do_reset();
    bus.data_in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_window", bus.window_out, '0);
    check("rst_valid", bus.window_valid, 1'b0);
    check("rst_col", bus.center_col, '0);
    check("rst_row", bus.center_row, '0);
    check("rst_line", bus.line_done, 1'b0);
    check("rst_frame", bus.frame_done, 1'b0);
    reset = 1'b1;
    check("sb_empty_at_reset", q.size(), 0);
    q.delete();
    mcol  = 0;
    mline = 0;
  endtask

  always @(negedge clk) begin
    if (reset && bus.window_valid) begin
      check("window_expected", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("center_col", bus.center_col, e.col);
        check("center_row", bus.center_row, e.row);
        check("window_out", bus.window_out, e.win);
        check("line_done", bus.line_done, e.line);
        check("frame_done", bus.frame_done, e.frame);
      end
    end
    if (reset && bus.frame_done) got_frames++;
  end

  initial begin
    bus.data_in_0     = '0;
    bus.data_in_1     = '0;
    bus.data_in_2     = '0;
    bus.data_in_valid = 1'b0;
    do_reset();
    idle(1, 1'b1);

    // Three continuous lines: a full frame then a wrapped row 0.
    for (int i = 0; i < 3 * DEPTH; i++) beat();
    idle(3, 1'b0);
    check("frame_done_once", got_frames, 1);

    // Stall mid-line after the third beat.
    for (int i = 0; i < 3; i++) beat();
    idle(4, 1'b1);
    for (int i = 0; i < 2; i++) beat();
    idle(3, 1'b0);

    // Reset with col_cnt at 3.
    for (int i = 0; i < 3; i++) beat();
    idle(1, 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) beat();
    idle(4, 1'b0);

    check("sb_drained", q.size(), 0);
    check("frame_count", got_frames, exp_frames);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sharpen_window_former.md
Name: sharpen_window_former

Overview:
- Consumer end of the three-row line-buffer tap interface.
- Takes the three vertically aligned row pixels produced each valid beat: data_in_0 is the newest line, data_in_2 the oldest.
- Builds a registered 3x3 pixel window with column shift registers.
- Tracks column and row position and presents each complete window, with its centre coordinates, to the sharpening kernel.

Parameters:
- WIDTH, 8, bits per pixel.
- DEPTH, 512, pixels per line; must be >= 3.
- LINE_BITS, 10, width of the column counter and center_col.
- HEIGHT, 512, lines per frame; must be >= 3.
- ROW_BITS, 10, width of the row counter and center_row.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- data_in_0  input  WIDTH  newest-line pixel (bottom window row).
- data_in_1  input  WIDTH  middle-line pixel (centre window row).
- data_in_2  input  WIDTH  oldest-line pixel (top window row).
- data_in_valid  input  1  the three row pixels are valid this cycle.
- window_out  output  9*WIDTH  3x3 window; element (r,c) at [WIDTH*(3*r+c) +: WIDTH]; r=0 top, c=0 leftmost/oldest column.
- window_valid  output  1  window_out and the coordinates are valid (one-cycle pulse per window).
- center_col  output  LINE_BITS  column index of the window centre.
- center_row  output  ROW_BITS  windowed-line index of the window centre, 0..HEIGHT-3.
- line_done  output  1  pulses with the last window of each line.
- frame_done  output  1  pulses with the last window of the frame.

Behaviour:
- Reset (reset==0 at a clock edge):
  - All outputs, shift registers and counters go to 0; FSM goes to FILL.
  - Reset mid-line or mid-frame discards partial state; the next valid beat is column 0 of row 0.
- Accepted beat (data_in_valid==1):
  - Each row shifts: col2 <= col1, col1 <= col0, col0 <= data_in_r.
  - col_cnt increments.
- data_in_valid==0: stall. All registers hold; window_valid, line_done and frame_done are 0 the next cycle. No timeout.
- FSM states:
  - FILL: col_cnt < 2. A beat only loads the shift registers; moves to ACTIVE on the beat with col_cnt==1.
  - ACTIVE: every beat emits a window registered one cycle later (latency 1).
    - Emitted values: center_col = col_cnt-1 (value before increment), center_row = row_cnt.
    - On the beat with col_cnt==DEPTH-1: col_cnt wraps to 0, line_done is asserted with that window, and the FSM moves to FILL (or FLUSH when BORDER_REPLICATE_EN is defined).
  - FLUSH: exists only when BORDER_REPLICATE_EN is defined (see Optional Feature).
- Row counting:
  - row_cnt increments at each line end.
  - At row_cnt==HEIGHT-3 line end, frame_done is asserted together with line_done, and row_cnt wraps to 0.
- Windows per line: DEPTH-2, with center_col 1..DEPTH-2. Windows per frame: (HEIGHT-2)*(DEPTH-2).
- No arithmetic on pixels; data is passed bit-exact.
- Timing: outputs are updated only on window cycles; window_out holds its last value otherwise.
- Back-to-back beats across a line boundary are accepted with no bubble. Column 0 of the next line enters FILL on the cycle after the last-column beat.

Optional Feature:
- Macro: BORDER_REPLICATE_EN.
- Defined: a window is emitted for every column (DEPTH windows per line).
  - The beat at col_cnt==1 emits the window for center_col 0, with the left column replicated from column 0.
  - After the col_cnt==DEPTH-1 beat (window for center DEPTH-2), the FSM enters FLUSH for exactly one cycle. It emits center_col DEPTH-1 with the right column replicated from column DEPTH-1, and line_done/frame_done move onto this window.
  - A beat arriving during FLUSH is accepted as column 0 of the next line. Column 0 never emits, so the output never collides.
- Undefined: FLUSH is not synthesised; edge columns produce no windows.

Test Plan:
- DEPTH=5, HEIGHT=4, rows driven with values r*16+c on continuous valid -> first window_valid appears one cycle after the third beat, with center_col=1 and top row {0x20,0x21,0x22}; 3 windows per line; line_done on center_col=3.
- Same frame fed continuously for 2 lines -> frame_done pulses exactly once, on row 1, col 3; center_row wraps to 0 on the next line.
- Insert data_in_valid=0 for 4 cycles after beat 3 -> no window during the gap; the next beat emits center_col=2 with correct contents and no duplicated window.
- Assert reset=0 for one cycle mid-line at col_cnt=3 -> all outputs 0 the next cycle; the following 2 beats emit nothing and the 3rd beat emits center_col=1, center_row=0.
- BORDER_REPLICATE_EN, DEPTH=5, continuous valid -> 5 windows per line. The center_col=0 window has column 0 equal to column 1. The FLUSH window has center_col=4 with right column equal to the centre column; a next-line beat during FLUSH loses no data.
